// File: rtl/array_18_rw_ctrl.sv
// array_18_rw_ctrl
// Single-port access controller in front of the array_18_ext SRAM macro.
// Write and read request channels share the one RW port: writes normally
// win, but a read that has lost STARVE_MAX arbitrations in a row is forced
// through. Read data coming back from the macro one cycle after the grant
// is captured in a small in-order response buffer, so a stalled consumer
// never loses data. Reads are only granted when a buffer slot is guaranteed.

module array_18_rw_ctrl #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 170,
    parameter int LANES      = 10,
    parameter int STARVE_MAX = 4,
    parameter int RESP_DEPTH = 3
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              wreq_valid,
    output logic              wreq_ready,
    input  logic [ADDR_W-1:0] wreq_addr,
    input  logic [LANES-1:0]  wreq_mask,
    input  logic [DATA_W-1:0] wreq_data,

    input  logic              rreq_valid,
    output logic              rreq_ready,
    input  logic [ADDR_W-1:0] rreq_addr,

    output logic              rresp_valid,
    input  logic              rresp_ready,
    output logic [DATA_W-1:0] rresp_data,

    output logic              sram_en,
    output logic              sram_wmode,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [LANES-1:0]  sram_wmask,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int OCC_W = $clog2(RESP_DEPTH + 1);
    localparam int SUM_W = OCC_W + 1;
    localparam int STV_W = $clog2(STARVE_MAX + 1);

    localparam logic [SUM_W-1:0] DEPTH_V  = SUM_W'(RESP_DEPTH);
    localparam logic [STV_W-1:0] STARVE_V = STV_W'(STARVE_MAX);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RESP_DEPTH - 1);

    logic [OCC_W-1:0]  occ;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic              inflight;
    logic [STV_W-1:0]  starve_cnt;
    logic [DATA_W-1:0] resp_mem [RESP_DEPTH];

    logic [SUM_W-1:0]  occ_sum;
    logic              rd_ok;
    logic              write_first;
    logic              read_win;
    logic              write_win;
    logic              push;
    logic              pop;

    // A read may only be granted if its response has a reserved buffer slot,
    // counting the read already on its way back from the macro.
    assign occ_sum     = {1'b0, occ} + SUM_W'(inflight);
    assign rd_ok       = rreq_valid && (occ_sum < DEPTH_V);
    assign write_first = wreq_valid && (starve_cnt < STARVE_V);
    assign read_win    = !write_first && rd_ok;
    assign write_win   = wreq_valid && !read_win;

    assign wreq_ready  = write_win;
    assign rreq_ready  = read_win;

    assign push        = inflight;
    assign pop         = rresp_valid && rresp_ready;

    assign rresp_valid = (occ != '0);
    assign rresp_data  = rresp_valid ? resp_mem[head] : '0;

    // Drive the macro port from the arbitration winner; a zero-mask write is
    // accepted but leaves the macro idle.
    always_comb begin
        sram_en    = 1'b0;
        sram_wmode = 1'b0;
        sram_addr  = '0;
        sram_wmask = '0;
        sram_wdata = '0;
        if (write_win && (wreq_mask != '0)) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = wreq_addr;
            sram_wmask = wreq_mask;
            sram_wdata = wreq_data;
        end else if (read_win) begin
            sram_en    = 1'b1;
            sram_addr  = rreq_addr;
        end
    end

    // Count consecutive arbitrations an eligible read has lost to a write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (read_win || !rd_ok) begin
            starve_cnt <= '0;
        end else if (write_win && (starve_cnt != STARVE_V)) begin
            starve_cnt <= starve_cnt + STV_W'(1);
        end
    end

    // Remember that the macro will present read data during the next cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inflight <= 1'b0;
        end else begin
            inflight <= read_win;
        end
    end

    // Response buffer bookkeeping: pointers and occupancy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            if (push) begin
                tail <= (tail == LAST_PTR) ? '0 : tail + PTR_W'(1);
            end
            if (pop) begin
                head <= (head == LAST_PTR) ? '0 : head + PTR_W'(1);
            end
            if (push && !pop) begin
                occ <= occ + OCC_W'(1);
            end else if (!push && pop) begin
                occ <= occ - OCC_W'(1);
            end
        end
    end

    // Capture returning read data; storage needs no reset because the
    // output is gated by occupancy.
    always_ff @(posedge clock) begin
        if (push) begin
            resp_mem[tail] <= sram_rdata;
        end
    end

endmodule

// File: tb/tb_array_18_rw_ctrl.sv
// tb_array_18_rw_ctrl
// Directed scenarios followed by a randomized phase. A behavioural SRAM
// stands in for the macro, and a reference model (golden memory, queue of
// expected responses, starvation counter) predicts every output each cycle.

module tb_array_18_rw_ctrl;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 170;
    localparam int LANES  = 10;
    localparam int LANE_W = 17;
    localparam int NWORDS = 2048;
    localparam int SMAX   = 4;
    localparam int DEPTH  = 3;

    logic              clock = 1'b0;
    logic              reset;
    logic              wreq_valid;
    logic              wreq_ready;
    logic [ADDR_W-1:0] wreq_addr;
    logic [LANES-1:0]  wreq_mask;
    logic [DATA_W-1:0] wreq_data;
    logic              rreq_valid;
    logic              rreq_ready;
    logic [ADDR_W-1:0] rreq_addr;
    logic              rresp_valid;
    logic              rresp_ready;
    logic [DATA_W-1:0] rresp_data;
    logic              sram_en;
    logic              sram_wmode;
    logic [ADDR_W-1:0] sram_addr;
    logic [LANES-1:0]  sram_wmask;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    int total = 0;
    int bad   = 0;

    // Behavioural macro contents and the bench's own golden copy.
    logic [DATA_W-1:0] sram_mem [NWORDS];
    logic [DATA_W-1:0] gold     [NWORDS];

    // Reference model state.
    int                starve_m;
    bit                infl_m;
    logic [DATA_W-1:0] infl_data;
    logic [DATA_W-1:0] resp_q [$];
    int                resp_seen;

    array_18_rw_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .wreq_valid  (wreq_valid),
        .wreq_ready  (wreq_ready),
        .wreq_addr   (wreq_addr),
        .wreq_mask   (wreq_mask),
        .wreq_data   (wreq_data),
        .rreq_valid  (rreq_valid),
        .rreq_ready  (rreq_ready),
        .rreq_addr   (rreq_addr),
        .rresp_valid (rresp_valid),
        .rresp_ready (rresp_ready),
        .rresp_data  (rresp_data),
        .sram_en     (sram_en),
        .sram_wmode  (sram_wmode),
        .sram_addr   (sram_addr),
        .sram_wmask  (sram_wmask),
        .sram_wdata  (sram_wdata),
        .sram_rdata  (sram_rdata)
    );

    always #5 clock = ~clock;

    function automatic logic [DATA_W-1:0] rand170();
        logic [191:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return t[DATA_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] mergeLanes(input logic [DATA_W-1:0] old,
                                                     input logic [DATA_W-1:0] data,
                                                     input logic [LANES-1:0]  mask);
        logic [DATA_W-1:0] r;
        r = old;
        for (int l = 0; l < LANES; l++) begin
            if (mask[l]) r[l*LANE_W +: LANE_W] = data[l*LANE_W +: LANE_W];
        end
        return r;
    endfunction

    // Macro model: lane-masked write, 1-cycle read latency, garbage otherwise.
    always @(posedge clock) begin
        if (sram_en && sram_wmode) begin
            sram_mem[sram_addr] = mergeLanes(sram_mem[sram_addr], sram_wdata, sram_wmask);
        end else if (sram_en) begin
            sram_rdata <= sram_mem[sram_addr];
        end else begin
            sram_rdata <= rand170();
        end
    end

    task automatic checkOutput(input string tag, input logic [DATA_W-1:0] obs,
                               input logic [DATA_W-1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic modelClear();
        starve_m = 0;
        infl_m   = 1'b0;
        resp_q.delete();
    endtask

    // Drive one cycle of requests, compare all outputs with the model, then
    // advance the model across the rising edge. Returns observed readies.
    task automatic applyStimulus(input bit wv, input logic [ADDR_W-1:0] wa,
                                 input logic [LANES-1:0] wm, input logic [DATA_W-1:0] wd,
                                 input bit rv, input logic [ADDR_W-1:0] ra,
                                 input bit rr, output bit obs_w, output bit obs_r);
        bit rd_ok, rwin, wwin, wen, evalid;
        logic [DATA_W-1:0] edata;
        wreq_valid  = wv;
        wreq_addr   = wa;
        wreq_mask   = wm;
        wreq_data   = wd;
        rreq_valid  = rv;
        rreq_addr   = ra;
        rresp_ready = rr;
        #1;
        rd_ok  = rv && ((resp_q.size() + int'(infl_m)) < DEPTH);
        rwin   = !(wv && starve_m < SMAX) && rd_ok;
        wwin   = wv && !rwin;
        wen    = wwin && (wm != '0);
        evalid = (resp_q.size() != 0);
        edata  = evalid ? resp_q[0] : '0;
        obs_w  = wreq_ready;
        obs_r  = rreq_ready;
        checkOutput("wreq_ready",  DATA_W'(wreq_ready),  DATA_W'(wwin));
        checkOutput("rreq_ready",  DATA_W'(rreq_ready),  DATA_W'(rwin));
        checkOutput("sram_en",     DATA_W'(sram_en),     DATA_W'(wen || rwin));
        checkOutput("sram_wmode",  DATA_W'(sram_wmode),  DATA_W'(wen));
        checkOutput("sram_addr",   DATA_W'(sram_addr),   wen ? DATA_W'(wa) : (rwin ? DATA_W'(ra) : '0));
        checkOutput("sram_wmask",  DATA_W'(sram_wmask),  wen ? DATA_W'(wm) : '0);
        checkOutput("sram_wdata",  sram_wdata,           wen ? wd : '0);
        checkOutput("rresp_valid", DATA_W'(rresp_valid), DATA_W'(evalid));
        checkOutput("rresp_data",  rresp_data,           edata);
        @(posedge clock);
        if (evalid && rr) begin
            void'(resp_q.pop_front());
            resp_seen++;
        end
        if (infl_m) resp_q.push_back(infl_data);
        infl_m = rwin;
        if (rwin) infl_data = gold[ra];
        if (wen) gold[wa] = mergeLanes(gold[wa], wd, wm);
        if (rwin || !rd_ok) starve_m = 0;
        else if (wwin && starve_m < SMAX) starve_m++;
        @(negedge clock);
    endtask

    initial begin
        bit ow, orr;
        int k, grants, seen0;
        logic [7:0] gvec;
        logic [DATA_W-1:0] pat, ones, expw;
        logic [ADDR_W-1:0] raddrs [5];

        for (int i = 0; i < NWORDS; i++) begin
            sram_mem[i] = '0;
            gold[i]     = '0;
        end
        sram_rdata  = '0;
        resp_seen   = 0;
        reset       = 1'b1;
        wreq_valid  = 1'b0;
        wreq_addr   = '0;
        wreq_mask   = '0;
        wreq_data   = '0;
        rreq_valid  = 1'b0;
        rreq_addr   = '0;
        rresp_ready = 1'b0;
        modelClear();
        #1;
        $display("[TB] reset values");
        checkOutput("rst_rresp_valid", DATA_W'(rresp_valid), '0);
        checkOutput("rst_rresp_data",  rresp_data, '0);
        checkOutput("rst_sram_en",     DATA_W'(sram_en), '0);
        rreq_valid = 1'b1;
        #1;
        checkOutput("rst_rreq_ready",  DATA_W'(rreq_ready), DATA_W'(1));
        rreq_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        $display("[TB] write then read-after-write");
        pat = rand170();
        applyStimulus(1, 11'h005, 10'h3FF, pat, 0, '0, 1, ow, orr);
        applyStimulus(0, '0, '0, '0, 1, 11'h005, 1, ow, orr);
        checkOutput("raw_grant", DATA_W'(orr), DATA_W'(1));
        applyStimulus(0, '0, '0, '0, 0, '0, 1, ow, orr);
        checkOutput("raw_valid", DATA_W'(rresp_valid), DATA_W'(1));
        checkOutput("raw_data",  rresp_data, pat);
        applyStimulus(0, '0, '0, '0, 0, '0, 1, ow, orr);

        $display("[TB] partial mask and zero mask");
        ones = '1;
        applyStimulus(1, 11'h010, 10'h3FF, ones, 0, '0, 1, ow, orr);
        applyStimulus(1, 11'h010, 10'h001, DATA_W'(17'h1ABCD), 0, '0, 1, ow, orr);
        applyStimulus(1, 11'h010, 10'h000, '0, 0, '0, 1, ow, orr);
        checkOutput("mask0_ready", DATA_W'(ow), DATA_W'(1));
        applyStimulus(0, '0, '0, '0, 1, 11'h010, 1, ow, orr);
        applyStimulus(0, '0, '0, '0, 0, '0, 1, ow, orr);
        expw = {{(DATA_W-LANE_W){1'b1}}, 17'h1ABCD};
        checkOutput("partial_data", rresp_data, expw);
        applyStimulus(0, '0, '0, '0, 0, '0, 1, ow, orr);

        $display("[TB] simultaneous write and read to the same address");
        pat = rand170();
        applyStimulus(1, 11'h7FF, 10'h3FF, pat, 1, 11'h7FF, 1, ow, orr);
        checkOutput("same_wfirst", DATA_W'({ow, orr}), DATA_W'(2'b10));
        applyStimulus(0, '0, '0, '0, 1, 11'h7FF, 1, ow, orr);
        checkOutput("same_rnext", DATA_W'(orr), DATA_W'(1));
        applyStimulus(0, '0, '0, '0, 0, '0, 1, ow, orr);
        checkOutput("same_data", rresp_data, pat);
        applyStimulus(0, '0, '0, '0, 0, '0, 1, ow, orr);

        $display("[TB] read starvation guard");
        gvec = '0;
        for (int c = 0; c < 8; c++) begin
            applyStimulus(1, ADDR_W'(11'h020 + c), 10'h3FF, rand170(), 1, 11'h021, 1, ow, orr);
            gvec[c] = orr;
        end
        checkOutput("starve_pattern", DATA_W'(gvec), DATA_W'(8'b0001_0000));
        for (int c = 0; c < 3; c++) applyStimulus(0, '0, '0, '0, 0, '0, 1, ow, orr);

        $display("[TB] buffer full under backpressure");
        for (int i = 0; i < 5; i++) begin
            raddrs[i] = ADDR_W'(11'h100 + i * 7);
            applyStimulus(1, raddrs[i], 10'h3FF, rand170(), 0, '0, 1, ow, orr);
        end
        k = 0;
        for (int c = 0; c < 5; c++) begin
            applyStimulus(0, '0, '0, '0, k < 5, (k < 5) ? raddrs[k] : '0, 0, ow, orr);
            if (orr) k++;
        end
        checkOutput("full_grants", DATA_W'(k), DATA_W'(3));
        checkOutput("full_rready", DATA_W'(rreq_ready), '0);
        seen0 = resp_seen;
        for (int c = 0; c < 12; c++) begin
            applyStimulus(0, '0, '0, '0, k < 5, (k < 5) ? raddrs[k] : '0, 1, ow, orr);
            if (orr) k++;
        end
        checkOutput("full_all_granted", DATA_W'(k), DATA_W'(5));
        checkOutput("full_all_returned", DATA_W'(resp_seen - seen0), DATA_W'(5));

        $display("[TB] sustained reads");
        grants = 0;
        for (int c = 0; c < 10; c++) begin
            applyStimulus(0, '0, '0, '0, 1, ADDR_W'(11'h100 + c), 1, ow, orr);
            if (orr) grants++;
        end
        checkOutput("sustained_grants", DATA_W'(grants), DATA_W'(10));
        for (int c = 0; c < 3; c++) applyStimulus(0, '0, '0, '0, 0, '0, 1, ow, orr);

        $display("[TB] reset with buffered and in-flight reads");
        for (int c = 0; c < 3; c++) begin
            applyStimulus(0, '0, '0, '0, 1, ADDR_W'(11'h101 + c), 0, ow, orr);
        end
        checkOutput("pre_reset_valid", DATA_W'(rresp_valid), DATA_W'(1));
        wreq_valid = 1'b0;
        rreq_valid = 1'b0;
        reset      = 1'b1;
        #1;
        checkOutput("mid_reset_valid", DATA_W'(rresp_valid), '0);
        checkOutput("mid_reset_data",  rresp_data, '0);
        @(negedge clock);
        reset = 1'b0;
        modelClear();
        for (int c = 0; c < 4; c++) applyStimulus(0, '0, '0, '0, 0, '0, 1, ow, orr);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 400; c++) begin
            logic [ADDR_W-1:0] wa, ra;
            logic [LANES-1:0]  wm;
            wa = ($urandom_range(0, 9) == 0) ? 11'h7FF : ADDR_W'($urandom_range(0, 7));
            ra = ($urandom_range(0, 9) == 0) ? 11'h7FF : ADDR_W'($urandom_range(0, 7));
            wm = ($urandom_range(0, 5) == 0) ? '0 : LANES'($urandom);
            applyStimulus($urandom_range(0, 2) != 0, wa, wm, rand170(),
                          $urandom_range(0, 2) != 0, ra, $urandom_range(0, 3) != 0, ow, orr);
        end
        for (int c = 0; c < 6; c++) applyStimulus(0, '0, '0, '0, 0, '0, 1, ow, orr);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
